// File: rtl/ddp_pkg.sv
// Shared types and constants for the data-driven pipe merge stage.
package ddp_pkg;

  localparam int unsigned PKT_W = 38;

  typedef logic [PKT_W-1:0] pkt_t;

  // Input slot handshake states
  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } in_state_e;

  // Output channel handshake states
  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_REQ  = 2'd1,
    O_REL  = 2'd2
  } out_state_e;

  localparam logic SRC_EX = 1'b1;
  localparam logic SRC_IN = 1'b0;

endpackage

// File: rtl/hs_in_slot.sv
// One-packet input buffer with a 4-phase Send/Ack receiver.
//  clk, rst_n : clock, async active-low reset
//  i_send     : source request
//  i_pkt      : source packet, stable while i_send=1
//  i_deq      : arbiter takes the buffered packet this cycle
//  o_ack      : acknowledge back to the source
//  o_full     : slot holds a packet
//  o_pkt      : buffered packet
module hs_in_slot
  import ddp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_send,
  input  pkt_t i_pkt,
  input  logic i_deq,
  output logic o_ack,
  output logic o_full,
  output pkt_t o_pkt
);

  in_state_e r_state;
  in_state_e w_state_nxt;
  logic      r_ack;
  logic      w_ack_nxt;
  logic      r_full;
  logic      w_full_nxt;
  logic      w_load;
  pkt_t      r_pkt;

  // State and buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_full  <= 1'b0;
      r_pkt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      r_full  <= w_full_nxt;
      if (w_load) r_pkt <= i_pkt;
    end
  end

  // Capture only into an empty slot; a dequeue frees it for the next cycle
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_full_nxt  = r_full;
    w_load      = 1'b0;
    if (i_deq) w_full_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_send && !r_full) begin
          w_load      = 1'b1;
          w_full_nxt  = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (!i_send) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_ack  = r_ack;
  assign o_full = r_full;
  assign o_pkt  = r_pkt;

endmodule

// File: rtl/merge_sched.sv
// Two-source merge scheduler: buffers one packet each from EX and IN and
// issues them, arbitrated, on a single 4-phase output channel.
//  CLK, MR_n              : clock, async active-low master reset
//  Send_in_EX/Ack_out_EX  : EX handshake, PACKET_IN_EXTERNAL payload
//  Send_in_IN/Ack_out_IN  : IN handshake, PACKET_IN_INTERNAL payload
//  Send_out/Ack_in        : downstream handshake, PACKET_OUT payload
//  Sel_EX                 : 1 when PACKET_OUT came from EX
module merge_sched
  import ddp_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             MR_n,
  input  logic             Send_in_EX,
  input  logic [PKT_W-1:0] PACKET_IN_EXTERNAL,
  output logic             Ack_out_EX,
  input  logic             Send_in_IN,
  input  logic [PKT_W-1:0] PACKET_IN_INTERNAL,
  output logic             Ack_out_IN,
  output logic             Send_out,
  output logic [PKT_W-1:0] PACKET_OUT,
  input  logic             Ack_in,
  output logic             Sel_EX
);

  logic       w_full_ex;
  logic       w_full_in;
  pkt_t       w_pkt_ex;
  pkt_t       w_pkt_in;
  logic       w_deq_ex;
  logic       w_deq_in;
  logic       w_win;

  out_state_e r_state;
  out_state_e w_state_nxt;
  logic       r_send;
  logic       w_send_nxt;
  pkt_t       r_pkt;
  pkt_t       w_pkt_nxt;
  logic       r_sel;
  logic       w_sel_nxt;
  logic       r_last;
  logic       w_last_nxt;

  hs_in_slot u_slot_ex (
    .clk    (CLK),
    .rst_n  (MR_n),
    .i_send (Send_in_EX),
    .i_pkt  (PACKET_IN_EXTERNAL),
    .i_deq  (w_deq_ex),
    .o_ack  (Ack_out_EX),
    .o_full (w_full_ex),
    .o_pkt  (w_pkt_ex)
  );

  hs_in_slot u_slot_in (
    .clk    (CLK),
    .rst_n  (MR_n),
    .i_send (Send_in_IN),
    .i_pkt  (PACKET_IN_INTERNAL),
    .i_deq  (w_deq_in),
    .o_ack  (Ack_out_IN),
    .o_full (w_full_in),
    .o_pkt  (w_pkt_in)
  );

  // Winner: the lone full slot, or on a tie the source not granted last (RR) / EX
  always_comb begin
    if (w_full_ex && w_full_in) w_win = RR_EN ? ~r_last : SRC_EX;
    else                        w_win = w_full_ex ? SRC_EX : SRC_IN;
  end

  // Output state and registered outputs; last_grant resets to IN so EX wins first
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      r_state <= O_IDLE;
      r_send  <= 1'b0;
      r_pkt   <= '0;
      r_sel   <= 1'b0;
      r_last  <= SRC_IN;
    end else begin
      r_state <= w_state_nxt;
      r_send  <= w_send_nxt;
      r_pkt   <= w_pkt_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Output handshake: issue in IDLE, drop request on Ack_in, rearm on release
  always_comb begin
    w_state_nxt = r_state;
    w_send_nxt  = r_send;
    w_pkt_nxt   = r_pkt;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_deq_ex    = 1'b0;
    w_deq_in    = 1'b0;
    case (r_state)
      O_IDLE: begin
        if (w_full_ex || w_full_in) begin
          w_pkt_nxt   = (w_win == SRC_EX) ? w_pkt_ex : w_pkt_in;
          w_sel_nxt   = (w_win == SRC_EX);
          w_deq_ex    = (w_win == SRC_EX);
          w_deq_in    = (w_win == SRC_IN);
          w_last_nxt  = w_win;
          w_send_nxt  = 1'b1;
          w_state_nxt = O_REQ;
        end
      end
      O_REQ: begin
        if (Ack_in) begin
          w_send_nxt  = 1'b0;
          w_state_nxt = O_REL;
        end
      end
      O_REL: begin
        if (!Ack_in) w_state_nxt = O_IDLE;
      end
      default: w_state_nxt = O_IDLE;
    endcase
  end

  assign Send_out   = r_send;
  assign PACKET_OUT = r_pkt;
  assign Sel_EX     = r_sel;

endmodule

// File: tb/tb_merge_sched.sv
// Directed bench for merge_sched: one round-robin and one fixed-priority
// instance share stimulus; use_fp selects which one is observed and acked.
module tb_merge_sched;
  import ddp_pkg::*;

  logic             clk = 1'b0;
  logic             MR_n = 1'b0;
  logic             Send_in_EX = 1'b0;
  logic [PKT_W-1:0] PACKET_IN_EXTERNAL = '0;
  logic             Send_in_IN = 1'b0;
  logic [PKT_W-1:0] PACKET_IN_INTERNAL = '0;
  logic             Ack_in = 1'b0;
  logic             ack_en = 1'b0;
  logic             use_fp = 1'b0;

  logic             rr_ack_ex, rr_ack_in, rr_send, rr_sel;
  logic [PKT_W-1:0] rr_pkt;
  logic             fp_ack_ex, fp_ack_in, fp_send, fp_sel;
  logic [PKT_W-1:0] fp_pkt;

  logic             Ack_out_EX, Ack_out_IN, Send_out, Sel_EX;
  logic [PKT_W-1:0] PACKET_OUT;

  int n_chk = 0;
  int n_err = 0;
  logic [PKT_W:0] log_q[$];
  logic prev_send = 1'b0;

  always #5 clk = ~clk;

  merge_sched #(.RR_EN(1'b1)) u_rr (
    .CLK(clk), .MR_n(MR_n),
    .Send_in_EX(Send_in_EX), .PACKET_IN_EXTERNAL(PACKET_IN_EXTERNAL), .Ack_out_EX(rr_ack_ex),
    .Send_in_IN(Send_in_IN), .PACKET_IN_INTERNAL(PACKET_IN_INTERNAL), .Ack_out_IN(rr_ack_in),
    .Send_out(rr_send), .PACKET_OUT(rr_pkt), .Ack_in(Ack_in), .Sel_EX(rr_sel)
  );

  merge_sched #(.RR_EN(1'b0)) u_fp (
    .CLK(clk), .MR_n(MR_n),
    .Send_in_EX(Send_in_EX), .PACKET_IN_EXTERNAL(PACKET_IN_EXTERNAL), .Ack_out_EX(fp_ack_ex),
    .Send_in_IN(Send_in_IN), .PACKET_IN_INTERNAL(PACKET_IN_INTERNAL), .Ack_out_IN(fp_ack_in),
    .Send_out(fp_send), .PACKET_OUT(fp_pkt), .Ack_in(Ack_in), .Sel_EX(fp_sel)
  );

  assign Ack_out_EX = use_fp ? fp_ack_ex : rr_ack_ex;
  assign Ack_out_IN = use_fp ? fp_ack_in : rr_ack_in;
  assign Send_out   = use_fp ? fp_send   : rr_send;
  assign Sel_EX     = use_fp ? fp_sel    : rr_sel;
  assign PACKET_OUT = use_fp ? fp_pkt    : rr_pkt;

  // Downstream: Ack_in echoes Send_out one cycle later when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      Ack_in = ack_en & Send_out;
    end
  end

  // Log every issued packet as {Sel_EX, PACKET_OUT}
  initial begin
    forever begin
      @(negedge clk);
      if (Send_out && !prev_send) log_q.push_back({Sel_EX, PACKET_OUT});
      prev_send = Send_out;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic fp);
    MR_n       = 1'b0;
    Send_in_EX = 1'b0;
    Send_in_IN = 1'b0;
    ack_en     = 1'b0;
    use_fp     = fp;
    repeat (3) @(negedge clk);
    MR_n = 1'b1;
    log_q.delete();
    @(negedge clk);
  endtask

  task automatic send_ex(input logic [PKT_W-1:0] p);
    int n = 0;
    Send_in_EX = 1'b1;
    PACKET_IN_EXTERNAL = p;
    while (!Ack_out_EX && n < 300) begin @(negedge clk); n++; end
    chk("ex_ack_timeout", 64'(n < 300), 64'd1);
    Send_in_EX = 1'b0;
    n = 0;
    while (Ack_out_EX && n < 300) begin @(negedge clk); n++; end
    chk("ex_rel_timeout", 64'(n < 300), 64'd1);
  endtask

  task automatic send_in(input logic [PKT_W-1:0] p);
    int n = 0;
    Send_in_IN = 1'b1;
    PACKET_IN_INTERNAL = p;
    while (!Ack_out_IN && n < 300) begin @(negedge clk); n++; end
    chk("in_ack_timeout", 64'(n < 300), 64'd1);
    Send_in_IN = 1'b0;
    n = 0;
    while (Ack_out_IN && n < 300) begin @(negedge clk); n++; end
    chk("in_rel_timeout", 64'(n < 300), 64'd1);
  endtask

  task automatic wait_log(input int n);
    int k = 0;
    while (log_q.size() < n && k < 400) begin @(negedge clk); k++; end
    chk("log_timeout", 64'(log_q.size() >= n), 64'd1);
  endtask

  initial begin
    logic [PKT_W:0] e;
    logic           seen;

    // Reset state
    @(negedge clk);
    chk("rst_send", 64'(Send_out), 64'd0);
    chk("rst_ack_ex", 64'(Ack_out_EX), 64'd0);
    chk("rst_ack_in", 64'(Ack_out_IN), 64'd0);
    chk("rst_pkt", 64'(PACKET_OUT), 64'd0);
    chk("rst_sel", 64'(Sel_EX), 64'd0);

    // 1: single EX packet, latency Ack t+1, Send_out t+2
    do_reset(1'b0);
    ack_en = 1'b1;
    Send_in_EX = 1'b1;
    PACKET_IN_EXTERNAL = 38'h0_1234_5678;
    @(negedge clk);
    chk("t1_ack_t1", 64'(Ack_out_EX), 64'd1);
    chk("t1_send_t1", 64'(Send_out), 64'd0);
    Send_in_EX = 1'b0;
    @(negedge clk);
    chk("t1_send_t2", 64'(Send_out), 64'd1);
    chk("t1_pkt", 64'(PACKET_OUT), 64'h0_1234_5678);
    chk("t1_sel", 64'(Sel_EX), 64'd1);
    chk("t1_ack_drop", 64'(Ack_out_EX), 64'd0);
    wait_log(1);
    repeat (4) @(negedge clk);
    chk("t1_no_dup", 64'(log_q.size()), 64'd1);

    // 2: round-robin, both sources, strict alternation from EX
    do_reset(1'b0);
    ack_en = 1'b1;
    fork
      for (int i = 0; i < 5; i++) send_ex(38'h1_0000_0000 + 38'(i));
      for (int i = 0; i < 5; i++) send_in(38'h2_0000_0000 + 38'(i));
    join
    wait_log(10);
    for (int i = 0; i < 10; i++) begin
      e = (i % 2 == 0) ? {1'b1, 38'h1_0000_0000 + 38'(i / 2)}
                       : {1'b0, 38'h2_0000_0000 + 38'(i / 2)};
      chk($sformatf("t2_rr_%0d", i), 64'(log_q[i]), 64'(e));
    end

    // 3: fixed priority, EX streaming starves IN until EX runs dry
    do_reset(1'b1);
    ack_en = 1'b1;
    fork
      for (int i = 0; i < 4; i++) send_ex(38'h3_0000_0000 + 38'(i));
      for (int i = 0; i < 2; i++) send_in(38'h4_0000_0000 + 38'(i));
    join
    wait_log(6);
    for (int i = 0; i < 6; i++) begin
      e = (i < 4) ? {1'b1, 38'h3_0000_0000 + 38'(i)}
                  : {1'b0, 38'h4_0000_0000 + 38'(i - 4)};
      chk($sformatf("t3_fp_%0d", i), 64'(log_q[i]), 64'(e));
    end

    // 4: downstream stalled, third EX packet held off with slot full
    do_reset(1'b0);
    send_ex(38'h0_AAAA_0001);
    send_ex(38'h0_AAAA_0002);
    Send_in_EX = 1'b1;
    PACKET_IN_EXTERNAL = 38'h0_AAAA_0003;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (Ack_out_EX) seen = 1'b1;
    end
    chk("t4_held_off", 64'(seen), 64'd0);
    chk("t4_send_hold", 64'(Send_out), 64'd1);
    chk("t4_pkt_hold", 64'(PACKET_OUT), 64'h0_AAAA_0001);
    ack_en = 1'b1;
    begin
      int n = 0;
      while (!Ack_out_EX && n < 300) begin @(negedge clk); n++; end
      chk("t4_ack3_timeout", 64'(n < 300), 64'd1);
      Send_in_EX = 1'b0;
    end
    wait_log(3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t4_order_%0d", i), 64'(log_q[i]), 64'({1'b1, 38'h0_AAAA_0001 + 38'(i)}));

    // 5: reset during O_REQ with both slots full
    do_reset(1'b0);
    send_ex(38'h0_5555_0001);
    send_ex(38'h0_5555_0002);
    send_in(38'h0_6666_0001);
    chk("t5_pre_send", 64'(Send_out), 64'd1);
    MR_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_send", 64'(Send_out), 64'd0);
    chk("t5_rst_pkt", 64'(PACKET_OUT), 64'd0);
    chk("t5_rst_sel", 64'(Sel_EX), 64'd0);
    chk("t5_rst_acks", 64'({Ack_out_EX, Ack_out_IN}), 64'd0);
    MR_n = 1'b1;
    ack_en = 1'b1;
    log_q.delete();
    repeat (6) @(negedge clk);
    chk("t5_slots_empty", 64'(log_q.size()), 64'd0);
    send_in(38'h0_7777_0001);
    wait_log(1);
    chk("t5_new_in", 64'(log_q[0]), 64'({1'b0, 38'h0_7777_0001}));

    // 6: IN pulse entirely between clock edges is never captured
    do_reset(1'b0);
    ack_en = 1'b1;
    @(posedge clk);
    #2 Send_in_IN = 1'b1;
    PACKET_IN_INTERNAL = 38'h0_DEAD_BEEF;
    #2 Send_in_IN = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (Ack_out_IN || Send_out) seen = 1'b1;
    end
    chk("t6_no_ack", 64'(seen), 64'd0);
    chk("t6_no_out", 64'(log_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
